// File: rtl/datagram_uart_tx.sv
// Serialises datagram snapshots onto TxD as sync, payload bytes, XOR checksum.
// Each byte is 8N1 LSB-first; an idle gap follows every frame.
module datagram_uart_tx #(
    parameter int          MSG_W        = 256,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          GAP_BITS     = 2,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic             clk_main,
    input  logic             rst,
    input  logic             en,
    input  logic [MSG_W-1:0] datagram,
    output logic             TxD,
    output logic             busy,
    output logic             frame_sent,
    output logic [7:0]       frame_count
);

    localparam int N        = MSG_W / 8;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(N + 2);
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SENT_AT  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] CSUM_IDX = BW'(N + 1);
    localparam logic [BW-1:0] PAY_END  = BW'(N);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t           state;
    logic [MSG_W-1:0] shadow;
    logic [8:0]       shreg;
    logic [7:0]       csum;
    logic [CW-1:0]    clk_cnt;
    logic [3:0]       bit_idx;
    logic [BW-1:0]    byte_idx;
    logic [GW-1:0]    gap_cnt;

    always_ff @(posedge clk_main or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            shreg       <= '1;
            csum        <= '0;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            TxD         <= 1'b1;
            busy        <= 1'b0;
            frame_sent  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_sent <= 1'b0;
            case (state)
                IDLE: begin
                    TxD  <= 1'b1;
                    busy <= 1'b0;
                    if (en) begin
                        // start bit goes out on the capture edge
                        shadow   <= datagram;
                        csum     <= '0;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        clk_cnt  <= '0;
                        shreg    <= {1'b1, SYNC_BYTE};
                        TxD      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (clk_cnt != BIT_LAST) begin
                        clk_cnt <= clk_cnt + CW'(1);
                        if (byte_idx == CSUM_IDX && bit_idx == 4'd9
                            && clk_cnt == SENT_AT) begin
                            frame_sent  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end
                    end else begin
                        clk_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            bit_idx <= bit_idx + 4'd1;
                            TxD     <= shreg[0];
                            shreg   <= {1'b1, shreg[8:1]};
                        end else if (byte_idx == CSUM_IDX) begin
                            bit_idx <= '0;
                            TxD     <= 1'b1;
                            gap_cnt <= '0;
                            if (GAP_CLKS == 0) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            bit_idx  <= '0;
                            byte_idx <= byte_idx + BW'(1);
                            TxD      <= 1'b0;
                            if (byte_idx < PAY_END) begin
                                // checksum folds in each byte as it is loaded
                                shreg  <= {1'b1, shadow[7:0]};
                                csum   <= csum ^ shadow[7:0];
                                shadow <= shadow >> 8;
                            end else begin
                                shreg <= {1'b1, csum};
                            end
                        end
                    end
                end
                GAP: begin
                    TxD <= 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    TxD   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datagram_uart_tx.sv
// Bench for datagram_uart_tx: per-cycle TxD/busy/frame_sent checks
// against a frame model built from byte lists and bit timing.
module tb_datagram_uart_tx;

    localparam int MSG_W = 16;
    localparam int CPB   = 4;
    localparam int GAPB  = 2;
    localparam int NB    = MSG_W / 8;
    localparam int BYTE_CLKS = 10 * CPB;
    localparam int SENT_K    = (NB + 2) * BYTE_CLKS;
    localparam int BUSY_K    = SENT_K + GAPB * CPB;

    logic             clk_main = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [MSG_W-1:0] datagram = '0;
    logic             TxD;
    logic             busy;
    logic             frame_sent;
    logic [7:0]       frame_count;

    int   n_checks = 0;
    int   n_fails = 0;
    int   pulses = 0;
    int   low_cycles = 0;
    logic [7:0] exp_count = 8'd0;

    datagram_uart_tx #(
        .MSG_W(MSG_W),
        .CLKS_PER_BIT(CPB),
        .GAP_BITS(GAPB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_main(clk_main),
        .rst(rst),
        .en(en),
        .datagram(datagram),
        .TxD(TxD),
        .busy(busy),
        .frame_sent(frame_sent),
        .frame_count(frame_count)
    );

    always #5 clk_main = ~clk_main;

    always @(negedge clk_main)
        if (frame_sent) pulses++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     tag, got, want, $time);
        end
    endtask

    // Expected TxD at cycle k (1-based) after the capture edge.
    function automatic logic exp_txd(input logic [MSG_W-1:0] dg, input int k);
        int i, byte_no, bit_no;
        logic [7:0] bytes [NB+2];
        logic [7:0] x;
        i = k - 1;
        byte_no = i / BYTE_CLKS;
        if (byte_no >= NB + 2) return 1'b1;
        x = 8'h00;
        bytes[0] = 8'hA5;
        for (int j = 0; j < NB; j++) begin
            bytes[j+1] = dg[8*j +: 8];
            x = x ^ dg[8*j +: 8];
        end
        bytes[NB+1] = x;
        bit_no = (i % BYTE_CLKS) / CPB;
        if (bit_no == 0) return 1'b0;
        if (bit_no == 9) return 1'b1;
        return bytes[byte_no][bit_no-1];
    endfunction

    // Starts from an IDLE negedge; ends on the IDLE negedge after the gap.
    task automatic run_frame(input logic [MSG_W-1:0] dg, input bit hold_en,
                             input bit mid_change, input bit abort);
        datagram = dg;
        en = 1'b1;
        low_cycles = 0;
        for (int k = 1; k <= BUSY_K + 1; k++) begin
            @(negedge clk_main);
            if (k == 1 && !hold_en) en = 1'b0;
            if (k == 50 && mid_change) datagram = 16'hFFFF;
            if (abort && k == 90) begin
                rst = 1'b1;
                #1;
                check("rst_txd", TxD, 1);
                check("rst_busy", busy, 0);
                check("rst_sent", frame_sent, 0);
                check("rst_count", frame_count, 0);
                exp_count = 8'd0;
                @(negedge clk_main);
                rst = 1'b0;
                return;
            end
            check("txd", TxD, exp_txd(dg, k));
            if (!TxD) low_cycles++;
            check("busy", busy, k <= BUSY_K);
            check("sent", frame_sent, k == SENT_K);
            if (k == SENT_K) exp_count = exp_count + 8'd1;
            check("count", frame_count, exp_count);
        end
    endtask

    initial begin
        int p0;
        logic [7:0] c0;
        logic [MSG_W-1:0] dg;

        repeat (2) @(negedge clk_main);
        check("reset_txd", TxD, 1);
        check("reset_busy", busy, 0);
        check("reset_sent", frame_sent, 0);
        check("reset_count", frame_count, 0);
        rst = 1'b0;
        @(negedge clk_main);

        // reset during byte 2, then a fresh frame
        run_frame(16'h1234, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk_main);
        check("post_rst_busy", busy, 0);
        check("post_rst_count", frame_count, 0);
        run_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        check("fresh_count", frame_count, 1);

        rst = 1'b1;
        @(negedge clk_main);
        rst = 1'b0;
        exp_count = 8'd0;
        @(negedge clk_main);

        // single pulse of en
        p0 = pulses;
        run_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        check("t1_count", frame_count, 1);
        check("t1_pulses", pulses - p0, 1);
        repeat (5) @(negedge clk_main);
        check("t1_no_restart", busy, 0);

        // datagram change mid-frame is ignored
        run_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        check("t2_count", frame_count, 2);

        // en held across three frames
        rst = 1'b1;
        @(negedge clk_main);
        rst = 1'b0;
        exp_count = 8'd0;
        @(negedge clk_main);
        for (int f = 0; f < 3; f++) run_frame(16'h1234, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        repeat (3) @(negedge clk_main);
        check("t3_idle", busy, 0);
        check("t3_count", frame_count, 3);

        // all-zero payload: low only for start + 8 data bits per byte
        run_frame(16'h0000, 1'b0, 1'b0, 1'b0);
        check("t6_low", low_cycles, (5 + 3 * 9) * CPB);

        // random payloads, also exercising the counter wrap
        c0 = frame_count;
        p0 = pulses;
        for (int f = 0; f < 256; f++) begin
            dg = MSG_W'($urandom);
            run_frame(dg, 1'b1, 1'b0, 1'b0);
        end
        en = 1'b0;
        repeat (3) @(negedge clk_main);
        check("t5_wrap", frame_count, c0);
        check("t5_pulses", pulses - p0, 256);
        check("t5_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
